// File: rtl/aes128_round_engine_if.sv
// Block handshake bundle for the AES-128 round engine: plaintext in, ciphertext out,
// each side carrying a sideband tag.
interface aes128_round_engine_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryptor: UNROLL chained rounds per clock, one block in flight,
// tag carried alongside the block, completed-block counter.
module aes128_round_engine #(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    aes128_round_engine_if.slave bus,
    input  logic [1407:0]        round_keys,
    output logic [31:0]          blk_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
            $error("aes128_round_engine: UNROLL must be 1, 2, 5 or 10");
        end
    endgenerate

    logic [1:0]       state;
    logic [3:0]       rnd;
    logic [127:0]     state_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [127:0]     chain [UNROLL+1];

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Indices past round 10 only occur while idle or holding a result; they select zero.
    function automatic logic [127:0] rk_at(input logic [1407:0] keys, input logic [4:0] idx);
        int base;
        if (idx > 5'd10) return '0;
        base = 1407 - 128 * int'(idx);
        return keys[base -: 128];
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic is_final);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   m [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127 - 8 * i -: 8]);
        // Bytes are column-major: row r of column c sits at index r + 4c.
        for (int i = 0; i < 16; i++) t[i] = b[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xtime(t[4*c]) ^ xtime(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+1] = t[4*c] ^ xtime(t[4*c+1]) ^ xtime(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xtime(t[4*c+2]) ^ xtime(t[4*c+3]) ^ t[4*c+3];
            m[4*c+3] = xtime(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xtime(t[4*c+3]);
        end
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = is_final ? t[i] : m[i];
        return r ^ rk;
    endfunction

    always_comb begin
        chain[0] = state_reg;
        for (int k = 0; k < UNROLL; k++) begin
            chain[k+1] = aes_round(chain[k], rk_at(round_keys, 5'(rnd) + 5'(k)),
                                   (5'(rnd) + 5'(k)) == 5'd10);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rnd       <= 4'd0;
            state_reg <= '0;
            tag_reg   <= '0;
            blk_count <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.in_data ^ rk_at(round_keys, 5'd0);
                        tag_reg   <= bus.in_tag;
                        rnd       <= 4'd1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_reg <= chain[UNROLL];
                    rnd       <= rnd + 4'(UNROLL);
                    if ((5'(rnd) + 5'(UNROLL)) == 5'd11) state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state     <= S_IDLE;
                        blk_count <= blk_count + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_data  = state_reg;
    assign bus.out_tag   = tag_reg;

endmodule

// File: tb/tb_aes128_round_engine.sv
// Bench for aes128_round_engine: all legal UNROLL values side by side, FIPS-197 vectors,
// back-pressure, reset, random streaming against a GF(2^8)-based AES model, counter wrap.
module tb_aes128_round_engine;
    localparam int NDUT  = 4;
    localparam int TAG_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [127:0]   in_data;
    logic [7:0]     in_tag;
    logic           out_ready;
    logic [1407:0]  round_keys;

    logic           ir [NDUT];
    logic           ov [NDUT];
    logic [127:0]   od [NDUT];
    logic [7:0]     ot [NDUT];
    logic [31:0]    bc [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int unroll_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    endfunction

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            aes128_round_engine_if #(.TAG_W(TAG_W)) bus ();
            assign bus.in_valid  = in_valid;
            assign bus.in_data   = in_data;
            assign bus.in_tag    = in_tag;
            assign bus.out_ready = out_ready;
            assign ir[g] = bus.in_ready;
            assign ov[g] = bus.out_valid;
            assign od[g] = bus.out_data;
            assign ot[g] = bus.out_tag;
            aes128_round_engine #(.UNROLL(unroll_of(g)), .TAG_W(TAG_W)) dut (
                .clk        (clk),
                .rst        (rst),
                .bus        (bus),
                .round_keys (round_keys),
                .blk_count  (bc[g])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   tmp;
        logic [7:0]    rcon;
        logic [1407:0] keys;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) keys[1407 - 32 * i -: 32] = w[i];
        return keys;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [1407:0] keys, input logic [127:0] pt);
        logic [7:0]   st [16];
        logic [7:0]   t  [16];
        logic [7:0]   acc;
        logic [7:0]   coef;
        logic [127:0] ct;
        int           d;
        for (int i = 0; i < 16; i++) st[i] = pt[127 - 8 * i -: 8] ^ keys[1407 - 8 * i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    t[row + 4 * col] = sb[st[row + 4 * ((col + row) % 4)]];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++) begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++) begin
                        d = (k - row + 4) % 4;
                        coef = (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
                        acc = acc ^ gmul(coef, t[k + 4 * col]);
                    end
                    st[row + 4 * col] = (r < 10) ? acc : t[row + 4 * col];
                end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ keys[1407 - 128 * r - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = st[i];
        return ct;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The key bus is not latched by the engine, so the bench must hold it while a block is in flight.
    logic          lock = 1'b0;
    logic [1407:0] saved_keys;
    always @(posedge clk) begin
        if (lock && !ov[0])
            assert (round_keys == saved_keys) else $error("round_keys changed while a block was in flight");
        if (rst) lock <= 1'b0;
        else if (ir[0] && in_valid) begin
            lock       <= 1'b1;
            saved_keys <= round_keys;
        end else if (ov[0]) lock <= 1'b0;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One block through DUT 0, starting from IDLE.
    task automatic xfer(input logic [127:0] key, input logic [127:0] pt, input logic [7:0] tag,
                        input logic [127:0] exp_ct, input string name);
        int n;
        @(negedge clk);
        round_keys = expand(key);
        in_data    = pt;
        in_tag     = tag;
        in_valid   = 1'b1;
        n = 0;
        while (!ir[0] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!ov[0] && n < 40) begin @(negedge clk); n++; end
        check({name, "_valid"}, 128'(ov[0]), 128'd1);
        check({name, "_ct"}, od[0], exp_ct);
        check({name, "_tag"}, 128'(ot[0]), 128'(tag));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [7:0]   tag;
        logic [127:0] ct;
    } vec_t;

    typedef struct {
        logic [127:0] ct;
        logic [7:0]   tag;
    } exp_t;

    exp_t exp_q [$];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t         vt [3];
        int           lat [NDUT];
        int           n;
        int           got;
        logic [127:0] key2, pt2, ct2;

        build_sbox();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0; round_keys = '0;

        vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  8'h5a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  8'ha5, 128'h3925841d02dc09fbdc118597196a0b32};
        vt[2] = '{128'h0, 128'h0, 8'h01, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("rst_in_ready_u%0d", unroll_of(g)), 128'(ir[g]), 128'd1);
            check($sformatf("rst_out_valid_u%0d", unroll_of(g)), 128'(ov[g]), 128'd0);
            check($sformatf("rst_out_data_u%0d", unroll_of(g)), od[g], 128'd0);
            check($sformatf("rst_out_tag_u%0d", unroll_of(g)), 128'(ot[g]), 128'd0);
            check($sformatf("rst_blk_count_u%0d", unroll_of(g)), 128'(bc[g]), 128'd0);
        end

        // Table vectors on every UNROLL at once, with exact latency
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            round_keys = expand(vt[v].key);
            in_data = vt[v].pt; in_tag = vt[v].tag; in_valid = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            for (int g = 0; g < NDUT; g++) lat[g] = 0;
            for (int c = 1; c <= 14; c++) begin
                for (int g = 0; g < NDUT; g++) if (lat[g] == 0 && ov[g]) lat[g] = c;
                @(negedge clk);
            end
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("vec%0d_u%0d_latency", v, unroll_of(g)), 128'(lat[g]),
                      128'(1 + 10 / unroll_of(g)));
                check($sformatf("vec%0d_u%0d_ct", v, unroll_of(g)), od[g], vt[v].ct);
                check($sformatf("vec%0d_u%0d_tag", v, unroll_of(g)), 128'(ot[g]), 128'(vt[v].tag));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            for (int g = 0; g < NDUT; g++)
                check($sformatf("vec%0d_u%0d_blk_count", v, unroll_of(g)), 128'(bc[g]), 128'(v + 1));
        end

        // Back-pressure with a second block knocking
        do_reset();
        @(negedge clk);
        round_keys = expand(vt[1].key);
        in_data = vt[1].pt; in_tag = vt[1].tag; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!ov[0] && n < 30) begin @(negedge clk); n++; end
        check("bp_first_valid", 128'(ov[0]), 128'd1);
        key2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt2  = {$urandom(), $urandom(), $urandom(), $urandom()};
        ct2  = ref_encrypt(expand(key2), pt2);
        round_keys = expand(key2);
        in_data = pt2; in_tag = 8'hc3;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c % 2 == 0);
            @(negedge clk);
            check($sformatf("bp_hold_data_c%0d", c), od[0], vt[1].ct);
            check($sformatf("bp_hold_flags_c%0d", c), 128'({ov[0], ir[0], ot[0]}), 128'({2'b10, vt[1].tag}));
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_blk_count", 128'(bc[0]), 128'd1);
        check("bp_release_in_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_accepted", 128'(ir[0]), 128'd0);
        n = 0;
        while (!ov[0] && n < 30) begin @(negedge clk); n++; end
        check("bp_second_ct", od[0], ct2);
        check("bp_second_tag", 128'(ot[0]), 128'h0c3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_blk_count_2", 128'(bc[0]), 128'd2);

        // Reset during RUN cycle 3, then reset against a simultaneous accept
        @(negedge clk);
        round_keys = expand(vt[0].key);
        in_data = vt[0].pt; in_tag = vt[0].tag; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(ir[0]), 128'd1);
        check("midrst_out_valid", 128'(ov[0]), 128'd0);
        check("midrst_blk_count", 128'(bc[0]), 128'd0);
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_beats_accept", 128'(ir[0]), 128'd1);
        xfer(vt[2].key, vt[2].pt, vt[2].tag, vt[2].ct, "after_rst");

        // Random streaming
        do_reset();
        got = 0;
        fork
            begin : driver
                logic [127:0] k, p;
                int           w;
                for (int i = 0; i < 100; i++) begin
                    k = {$urandom(), $urandom(), $urandom(), $urandom()};
                    p = {$urandom(), $urandom(), $urandom(), $urandom()};
                    w = 0;
                    while (!ir[0] && w < 200) begin @(negedge clk); w++; end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    round_keys = expand(k);
                    in_data = p; in_tag = 8'(i); in_valid = 1'b1;
                    exp_q.push_back('{ref_encrypt(round_keys, p), 8'(i)});
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            begin : monitor
                exp_t e;
                int   cyc = 0;
                while (got < 100 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_ready && ov[0]) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("stream_unexpected_%0d", got), od[0], 128'hx);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("stream_ct_%0d", got), od[0], e.ct);
                            check($sformatf("stream_tag_%0d", got), 128'(ot[0]), 128'(e.tag));
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        out_ready = 1'b0;
        check("stream_received", 128'(got), 128'd100);
        check("stream_blk_count", 128'(bc[0]), 128'd100);

        // Counter wrap
        @(negedge clk);
        force g_dut[0].dut.blk_count = 32'hffffffff;
        #1;
        release g_dut[0].dut.blk_count;
        xfer(vt[0].key, vt[0].pt, vt[0].tag, vt[0].ct, "wrap");
        check("wrap_blk_count", 128'(bc[0]), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
